// File: rtl/conv_bram_1d_img_loader.sv
`timescale 1ns/1ps
// Double-buffered column loader: fills two ping-pong banks from a valid/ready
// stream, starts the conv engine on a full bank and serves its per-channel reads.
module conv_bram_1d_img_loader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 32,
    parameter int unsigned IMG_D      = 4,
    localparam int unsigned IMG_RAM_ADDR_WIDTH = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH*IMG_D-1:0]         in_data,
    input  logic                                in_val,
    output logic                                in_rdy,
    output logic                                conv_val,
    input  logic                                conv_rdy,
    input  logic [IMG_RAM_ADDR_WIDTH*IMG_D-1:0] img_rdaddr,
    output logic [DATA_WIDTH*IMG_D-1:0]         img_rddata,
    output logic [1:0]                          bank_full
);
    localparam int unsigned AW = IMG_RAM_ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_HOLD, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [AW-1:0]       r_wr_ptr;
    logic [1:0]          r_bank_full;
    logic [DW*IMG_D-1:0] r_img_rddata;
    logic [DW-1:0]       r_mem [2][IMG_D][IMG_W];

    logic                w_accept;
    logic                w_last;
    logic                w_release;
    logic [1:0]          w_set_mask;
    logic [1:0]          w_clr_mask;

    assign in_rdy     = !reset && !r_bank_full[r_wr_bank];
    assign w_accept   = in_val && in_rdy;
    assign w_last     = (r_wr_ptr == AW'(IMG_W - 1));
    // Set and clear always target different banks, so both may land together.
    assign w_set_mask = (w_accept && w_last) ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr_mask = w_release ? (2'b01 << r_rd_bank) : 2'b00;

    assign conv_val   = (r_state == S_OFFER);
    assign bank_full  = r_bank_full;
    assign img_rddata = r_img_rddata;

    // Bank storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int c = 0; c < int'(IMG_D); c++) begin
                r_mem[r_wr_bank][c][r_wr_ptr] <= in_data[c*DW +: DW];
            end
        end
    end

    // Writer pointer and bank select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_wr_bank <= ~r_wr_bank;
                r_wr_ptr  <= '0;
            end else begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
            end
        end
    end

    // Reader state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reader next-state; HOLD skips the cycle where the engine still shows rdy.
    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE:  if (r_bank_full[r_rd_bank]) w_state_nxt = S_OFFER;
            S_OFFER: if (conv_rdy) w_state_nxt = S_HOLD;
            S_HOLD:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (conv_rdy) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bank status, read bank and registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_bank    <= 1'b0;
            r_bank_full  <= 2'b00;
            r_img_rddata <= '0;
        end else begin
            r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            for (int c = 0; c < int'(IMG_D); c++) begin
                r_img_rddata[c*DW +: DW] <= r_mem[r_rd_bank][c][img_rdaddr[c*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_conv_bram_1d_img_loader.sv
`timescale 1ns/1ps
// Scoreboarded bench: frames are queued when their last beat is accepted; the
// conv engine model pops one per start and checks every word it reads back.
module tb_conv_bram_1d_img_loader;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 32;
    localparam int unsigned ID = 4;
    localparam int unsigned AW = 5;
    localparam int BEAT_BUDGET = 2000;

    logic             clk = 1'b0;
    logic             reset;
    logic [DW*ID-1:0] in_data;
    logic             in_val;
    logic             in_rdy;
    logic             conv_val;
    logic             conv_rdy;
    logic [AW*ID-1:0] img_rdaddr;
    logic [DW*ID-1:0] img_rddata;
    logic [1:0]       bank_full;

    int checks = 0;
    int errors = 0;
    int q[$];
    int pushed = 0;
    int starts = 0;
    int releases = 0;
    int eng_len = 40;
    bit eng_en = 1'b1;
    bit eng_rand = 1'b0;
    bit hold_release = 1'b0;
    bit eng_holding = 1'b0;
    bit eng_busy = 1'b0;
    bit exp_rd = 1'b0;

    conv_bram_1d_img_loader #(
        .DATA_WIDTH(DW),
        .IMG_W(IW),
        .IMG_D(ID)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_val(in_val),
        .in_rdy(in_rdy),
        .conv_val(conv_val),
        .conv_rdy(conv_rdy),
        .img_rdaddr(img_rdaddr),
        .img_rddata(img_rddata),
        .bank_full(bank_full)
    );

    always #5 clk = ~clk;

    // Frame 0 gives 4k+c; other frames XOR a distinct byte so frames never alias.
    function automatic logic [DW-1:0] pix(input int f, input int k, input int c);
        return DW'(4*k + c) ^ DW'(f*53);
    endfunction

    function automatic logic [DW*ID-1:0] col(input int f, input int k);
        logic [DW*ID-1:0] v;
        for (int c = 0; c < int'(ID); c++) v[c*DW +: DW] = pix(f, k, c);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic send_beat(input int f, input int k, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 4) == 0) begin
                in_val = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_val  = 1'b1;
        in_data = col(f, k);
        n = 0;
        while (!in_rdy && n < BEAT_BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout frame=%0d beat=%0d in_rdy stayed 0", f, k);
        end else begin
            @(posedge clk); #1;
        end
        in_val = 1'b0;
    endtask

    task automatic send_frame(input int f, input int n, input bit push, input bit gaps);
        for (int k = 0; k < n; k++) send_beat(f, k, gaps);
        if (push) begin
            q.push_back(f);
            pushed++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(q.size() == 0 && !eng_busy && bank_full == 2'b00) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout queued=%0d bank_full=%0b required empty", q.size(), bank_full);
        end
    endtask

    // Conv engine model and monitor: accepts a start, reads the bank, releases.
    initial begin : engine
        int f;
        int len;
        bit have;
        logic [AW*ID-1:0] a;
        logic [DW*ID-1:0] e;
        conv_rdy   = 1'b0;
        img_rdaddr = '0;
        e = '0;
        forever begin
            @(posedge clk); #1;
            conv_rdy = eng_en;
            while (!(conv_val && conv_rdy)) begin
                @(posedge clk); #1;
                conv_rdy = eng_en;
            end
            starts++;
            eng_busy = 1'b1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL start_unexpected actual=start required=no_frame_queued");
                f = -1;
            end else begin
                f = q.pop_front();
            end
            check("start_bank_full", 32'(bank_full[exp_rd]), 32'd1);
            @(posedge clk); #1;
            conv_rdy = 1'b0;
            len = eng_rand ? int'($urandom_range(10, 100)) : eng_len;
            have = 1'b0;
            for (int i = 0; i <= len; i++) begin
                if (have) check("rd_data", img_rddata, e);
                have = 1'b0;
                if (i < len && i < int'(IW)) begin
                    for (int c = 0; c < int'(ID); c++) begin
                        a[c*AW +: AW] = AW'((i + 5*c) % int'(IW));
                        e[c*DW +: DW] = pix(f, (i + 5*c) % int'(IW), c);
                    end
                    img_rdaddr = a;
                    have = 1'b1;
                end
                if (i < len) begin
                    @(posedge clk); #1;
                end
            end
            if (hold_release) begin
                eng_holding = 1'b1;
                while (hold_release) @(negedge clk);
                @(posedge clk); #1;
                eng_holding = 1'b0;
            end
            conv_rdy = 1'b1;
            @(posedge clk); #1;
            check("release_clears", 32'(bank_full[exp_rd]), 32'd0);
            exp_rd = ~exp_rd;
            releases++;
            eng_busy = 1'b0;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        reset   = 1'b1;
        in_val  = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        check("rst_bank_full", 32'(bank_full), 32'd0);
        check("rst_conv_val", 32'(conv_val), 32'd0);
        check("rst_rddata", img_rddata, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_exit_in_rdy", 32'(in_rdy), 32'd1);

        // Single frame: start two cycles after the last beat.
        send_frame(0, IW, 1'b1, 1'b0);
        check("single_bank_full", 32'(bank_full), 32'd1);
        check("single_conv_val_early", 32'(conv_val), 32'd0);
        @(posedge clk); #1;
        check("single_conv_val_rise", 32'(conv_val), 32'd1);
        drain(500);

        // Backpressure: engine never ready, both banks fill, beat 64 stalls.
        eng_en = 1'b0;
        @(posedge clk); #1;
        send_frame(1, IW, 1'b1, 1'b0);
        send_frame(2, IW, 1'b1, 1'b0);
        check("bp_bank_full", 32'(bank_full), 32'd3);
        check("bp_in_rdy", 32'(in_rdy), 32'd0);
        in_val  = 1'b1;
        in_data = col(3, 0);
        repeat (4) begin
            @(posedge clk); #1;
            check("bp_stall_in_rdy", 32'(in_rdy), 32'd0);
            check("bp_conv_val_held", 32'(conv_val), 32'd1);
        end
        in_val = 1'b0;
        eng_en = 1'b1;
        drain(2000);

        // Ping-pong overlap: frame 4 loads while frame 3 computes.
        eng_len = 60;
        send_frame(3, IW, 1'b1, 1'b0);
        send_frame(4, IW, 1'b1, 1'b0);
        drain(2000);
        eng_len = 40;

        // Last beat of bank 0 lands in the cycle RUN releases bank 1.
        hold_release = 1'b1;
        send_frame(5, IW, 1'b1, 1'b0);
        send_frame(6, IW - 1, 1'b0, 1'b0);
        n = 0;
        while (!eng_holding && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("sim_engine_holding", 32'(eng_holding), 32'd1);
        hold_release = 1'b0;
        @(posedge clk); #1;
        send_beat(6, IW - 1, 1'b0);
        q.push_back(6);
        pushed++;
        check("sim_bank_full", 32'(bank_full), 32'd1);
        check("sim_in_rdy", 32'(in_rdy), 32'd1);
        drain(2000);

        // Reset mid-load discards the partial frame.
        send_frame(7, 10, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_in_rdy", 32'(in_rdy), 32'd0);
        @(posedge clk); #1;
        check("midrst_bank_full", 32'(bank_full), 32'd0);
        check("midrst_conv_val", 32'(conv_val), 32'd0);
        reset  = 1'b0;
        exp_rd = 1'b0;
        #1;
        check("midrst_exit_in_rdy", 32'(in_rdy), 32'd1);
        send_frame(8, IW, 1'b1, 1'b0);
        check("midrst_conv_val_early", 32'(conv_val), 32'd0);
        @(posedge clk); #1;
        check("midrst_conv_val_rise", 32'(conv_val), 32'd1);
        drain(1000);

        // Random in_val gaps and compute lengths over 8 frames.
        eng_rand = 1'b1;
        for (int f = 9; f < 17; f++) send_frame(f, IW, 1'b1, 1'b1);
        drain(20000);

        check("frames_started", 32'(starts), 32'(pushed));
        check("frames_released", 32'(releases), 32'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_bram_1d_img_loader.md
# conv_bram_1d_img_loader

Double-buffered image front end for the 1-D BRAM convolution engine. Accepts image columns as a valid/ready stream (one column of IMG_D channels per beat), stores each IMG_W-column image in one of two ping-pong banks, and starts the conv engine once a bank is full. It then serves the engine's per-channel image read port from that bank. The next image can be filled into the other bank while the engine computes, hiding load time behind convolution.

## Interface
- DATA_WIDTH, 8, bits per pixel per channel
- IMG_W, 32, columns per image (beats per frame)
- IMG_D, 4, channels per column
- IMG_RAM_ADDR_WIDTH, $clog2(IMG_W), per-channel read address width (derived, not set manually)
- clk  input  1  single clock, all logic rising-edge
- reset  input  1  asynchronous, active-high
- in_data  input  DATA_WIDTH*IMG_D  one column; channel c at [(c+1)*DATA_WIDTH-1:c*DATA_WIDTH]
- in_val  input  1  in_data valid
- in_rdy  output  1  loader can accept a beat
- conv_val  output  1  start request to conv engine (drives its val_in)
- conv_rdy  input  1  conv engine ready (its rdy_in)
- img_rdaddr  input  IMG_RAM_ADDR_WIDTH*IMG_D  per-channel read address from engine; lane c addresses channel c
- img_rddata  output  DATA_WIDTH*IMG_D  per-channel read data, lane c = channel c
- bank_full  output  2  status: bit b set while bank b holds an unconsumed image

## Operation
- Storage: 2 banks × IMG_D channel memories × IMG_W words × DATA_WIDTH. Memory contents not reset.
- Writer: registers wr_bank (1 bit) and wr_ptr (0..IMG_W-1).
  - in_rdy = !reset && !bank_full[wr_bank].
  - On in_val && in_rdy: write column to bank wr_bank, address wr_ptr.
  - If wr_ptr == IMG_W-1: set bank_full[wr_bank], toggle wr_bank, wr_ptr <= 0. Otherwise wr_ptr++.
- Reader FSM: register rd_bank (1 bit); states IDLE, OFFER, HOLD, RUN.
  - IDLE: if bank_full[rd_bank], go to OFFER.
  - OFFER: conv_val = 1. On conv_rdy, go to HOLD; otherwise stay. conv_val stays high until accepted.
  - HOLD: single cycle; conv_rdy ignored, since the engine drops rdy after start. Go to RUN.
  - RUN: on first cycle with conv_rdy == 1, clear bank_full[rd_bank], toggle rd_bank, go to IDLE.
- conv_val is a decoded state output (state == OFFER), glitch-free from registers.
- Read port: img_rddata lane c <= bank[rd_bank].chan[c][img_rdaddr lane c], registered. Served in every state, including IDLE. Address ≥ IMG_W gives don't-care data.
- Simultaneous events:
  - Writer sets bank_full for one bank while reader clears it for the other in the same cycle: both take effect.
  - The writer never targets a full bank, so the same bit is never set and cleared at once.
- Ordering: images are consumed strictly in arrival order (wr_bank and rd_bank both start at 0 and alternate).
- Reset (any time, asynchronous): state IDLE, wr_bank = rd_bank = 0, wr_ptr = 0, bank_full = 2'b00, conv_val = 0, img_rddata = 0, in_rdy = 0 while reset is high.
  - A partially loaded or in-flight image is discarded.
  - in_rdy = 1 the first cycle after reset deasserts.

## Timing
- Read latency: 1 cycle, address in cycle t gives data in cycle t+1.
- Last beat accepted in cycle t: bank_full bit high in t+1, conv_val high in t+2 if the reader is IDLE on that bank.
- Start handshake: conv_val && conv_rdy in cycle t; conv_val low in t+1.
- Bank release: conv_rdy high in RUN at cycle t; bank_full bit low in t+1; the writer may write that bank from t+1.
- Streaming: with both banks free, in_rdy holds high for 2*IMG_W consecutive beats, then drops until a release.
- Sustained throughput: 1 beat/cycle while the engine's compute time ≥ IMG_W cycles.

## Test plan
- Single frame, IMG_W=32, IMG_D=4:
  - Stimulus: stream columns with channel c of column k = 4k+c, in_val constant; conv model holds rdy=1, then drops it 1 cycle after start.
  - Required: conv_val rises 2 cycles after beat 31 and img_rddata lane c at address k returns 4k+c the next cycle.
- Backpressure fill:
  - Stimulus: conv_rdy held 0, send 64 beats.
  - Required: bank_full = 2'b11 and in_rdy = 0 after beat 63; beat 64 is stalled; conv_val stays high, unaccepted.
- Ping-pong overlap:
  - Stimulus: frame A in compute while frame B loads.
  - Required: the engine reads A data throughout; after the release, rd_bank = 1 and B data is served; frames never mix.
- Simultaneous release and fill:
  - Stimulus: the last beat of bank 0 lands in the same cycle RUN releases bank 1.
  - Required: next cycle bank_full = 2'b01 and in_rdy = 1 (writer on bank 1).
- Reset mid-load:
  - Stimulus: assert reset after 10 beats, release it, send 32 new beats.
  - Required: conv_val only after the new 32nd beat; all data read back comes from the new frame.
- Random in_val gaps:
  - Stimulus: 20% idle cycles on in_val, random conv compute length (10–100 cycles), 8 frames.
  - Required: all frames start the engine in order, with no lost or duplicated beats (checked by scoreboard).
